// File: rtl/instr_fetch.sv
// instr_fetch: fetches the instruction at the PC and lets the PC register advance only when it retires
module instr_fetch #(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] pc_i,
  input  logic                 halt_req_i,
  output logic                 halt_o,
  output logic                 imem_req_o,
  output logic [AddrWidth-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [DataWidth-1:0] imem_rdata_i,
  output logic [DataWidth-1:0] instr_o,
  output logic                 instr_valid_o,
  output logic                 fetch_fault_o
);
  localparam int CW = $clog2(TimeoutCycles + 1);
  localparam logic [CW-1:0] TMAX = CW'(TimeoutCycles);
  typedef enum logic [1:0] {REQ, WAIT, EXEC, FAULT} state_e;
  state_e                 state_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DataWidth-1:0]   instr_q;
  logic                   valid_q, halt_q, fault_q;
  logic                   misaligned;
  assign misaligned    = pc_i[1:0] != 2'b00;
  assign imem_req_o    = state_q == REQ && !halt_req_i && !misaligned && !rst_i;
  assign imem_addr_o   = pc_i;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign halt_o        = halt_q;
  assign fetch_fault_o = fault_q;
  // Response-wait counter advances but never wraps past the timeout value
  always_comb cnt_d = cnt_q == TMAX ? cnt_q : cnt_q + CW'(1);
  // Fetch sequencer; retire strobe and PC halt are registered alongside the state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= REQ;
      cnt_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      halt_q  <= 1'b1;
      fault_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      halt_q  <= 1'b1;
      case (state_q)
        REQ: begin
          if (misaligned) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
          end else if (imem_req_o && imem_gnt_i) begin
            state_q <= WAIT;
            cnt_q   <= '0;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            instr_q <= imem_rdata_i;
            state_q <= EXEC;
            valid_q <= 1'b1;
            halt_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == TMAX) begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end
          end
        end
        EXEC:    state_q <= REQ;
        default: fault_q <= 1'b1;
      endcase
    end
  end
endmodule
